// File: rtl/core_alu_seq.sv
// core_alu_seq: single-issue sequential ALU with a valid/ready front end.
// Non-shift ops finish in one cycle; shifts with a non-zero count walk the
// result register one bit per cycle before presenting it. A DONE result is
// held stable until the consumer takes it, and FLUSH aborts anything in flight.
module core_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      opcode_alu,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            err,
  output logic            busy
);

  localparam int SHW = 5;  // shift-count width for a 32-bit datapath

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_SUM  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  state_t          state_reg, state_next;
  logic [3:0]      op_reg, op_next;
  logic [SHW-1:0]  shamt_reg, shamt_next;
  logic [4:0]      rd_reg, rd_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            err_reg, err_next;

  logic            accept;
  logic            op_is_shift;
  logic            op_is_valid;
  logic [SHW-1:0]  in_count;
  logic [XLEN-1:0] alu_value;
  logic [XLEN-1:0] shl_step;
  logic [XLEN-1:0] shr_step;

  // Handshake: a new op is taken when idle, or when the held result is being
  // retired in the same cycle; a flush blocks any simultaneous offer.
  assign in_ready = !flush && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign in_count = op_b[SHW-1:0];

  // Single-cycle ALU evaluated on the offered operands. Shift opcodes yield
  // OP_A here: that is the zero-count answer and the shifter's starting value.
  always_comb begin
    alu_value   = '0;
    op_is_shift = 1'b0;
    op_is_valid = 1'b1;
    case (opcode_alu)
      OP_SUM:  alu_value = op_a + op_b;
      OP_SUB:  alu_value = op_a - op_b;
      OP_XOR:  alu_value = op_a ^ op_b;
      OP_OR:   alu_value = op_a | op_b;
      OP_AND:  alu_value = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_value   = op_a;
        op_is_shift = 1'b1;
      end
      OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: begin
        alu_value   = '0;
        op_is_valid = 1'b0;
      end
    endcase
  end

  // One-bit shift step of the result register, built bit by bit. The top bit
  // of a right shift replicates the sign only for SRA.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign shl_step[gi] = 1'b0;
      end else begin : g_lo
        assign shl_step[gi] = result_reg[gi-1];
      end
      if (gi == XLEN - 1) begin : g_msb
        assign shr_step[gi] = (op_reg == OP_SRA) ? result_reg[XLEN-1] : 1'b0;
      end else begin : g_hi
        assign shr_step[gi] = result_reg[gi+1];
      end
    end
  endgenerate

  // Next-state and datapath update: flush wins, then per-state work, then an
  // accept (which may overlap retirement in DONE) overrides the state choice.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    shamt_next  = shamt_reg;
    rd_next     = rd_reg;
    result_next = result_reg;
    err_next    = err_reg;

    if (flush) begin
      state_next = IDLE;
      shamt_next = '0;
    end else begin
      case (state_reg)
        SHIFT: begin
          result_next = (op_reg == OP_SLL) ? shl_step : shr_step;
          shamt_next  = shamt_reg - 1'b1;
          if (shamt_reg == SHW'(1)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase

      if (accept) begin
        op_next     = opcode_alu;
        rd_next     = rd_in;
        err_next    = !op_is_valid;
        result_next = alu_value;
        if (op_is_shift && (in_count != '0)) begin
          shamt_next = in_count;
          state_next = SHIFT;
        end else begin
          shamt_next = '0;
          state_next = DONE;
        end
      end
    end
  end

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      shamt_reg  <= '0;
      rd_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      shamt_reg  <= shamt_next;
      rd_reg     <= rd_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign rd_out    = rd_reg;
  assign err       = err_reg;

endmodule

// File: doc/core_alu_seq.md
CORE_ALU_SEQ -- requirements
Module: core_alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 The block SHALL have port CLK, input, 1, sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port NRST, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port IN_VALID, input, 1: an operation is offered.
REQ-005 The block SHALL have port IN_READY, output, 1: an offered operation is accepted this cycle.
REQ-006 The block SHALL have port OPCODE_ALU, input, 4, with ALU code SUM=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9; all other codes are invalid.
REQ-007 The block SHALL have port OP_A, input, 32: first operand.
REQ-008 The block SHALL have port OP_B, input, 32: second operand, either rs2 or ALU_IMM.
REQ-009 The block SHALL have port RD_IN, input, 5: destination register tag.
REQ-010 The block SHALL have port FLUSH, input, 1: synchronous abort.
REQ-011 The block SHALL have port OUT_VALID, output, 1: a result is presented.
REQ-012 The block SHALL have port OUT_READY, input, 1: the consumer takes the result.
REQ-013 The block SHALL have port RESULT, output, 32: registered result.
REQ-014 The block SHALL have port RD_OUT, output, 5: registered tag of the result.
REQ-015 The block SHALL have port ERR, output, 1: the result comes from an invalid opcode.
REQ-016 The block SHALL have port BUSY, output, 1: high when the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 IN_READY SHALL be (IDLE) OR (DONE AND OUT_READY), and SHALL be held 0 whenever FLUSH=1.
REQ-019 On accept, the block SHALL latch the opcode, OP_A, OP_B[4:0] as the shift count, the full OP_B and RD_IN.
REQ-020 An accepted non-shift op SHALL write RESULT and go to DONE, so OUT_VALID rises the next cycle (latency 1).
  - SUM/SUB: mod 2^32.
  - SLT: signed compare.
  - SLTU: unsigned compare; result 0 or 1.
REQ-021 For an accepted SLL/SRL/SRA with count 0, the block SHALL set RESULT=OP_A and go to DONE (latency 1).
REQ-022 For an accepted shift with count n>0, the block SHALL load OP_A into RESULT, enter SHIFT, and shift one bit per cycle for n cycles, decrementing the count.
  - SRA fills with bit 31.
  - SRL and SLL fill with 0.
  - Enters DONE when the count reaches 0.
  - OUT_VALID is high n+1 cycles after accept.
REQ-023 An invalid opcode SHALL give RESULT=0 and ERR=1 in DONE, with latency 1; ERR SHALL be 0 for valid opcodes.
REQ-024 In DONE, OUT_VALID=1 and RESULT, RD_OUT and ERR SHALL stay stable until OUT_READY=1.
REQ-025 When DONE, OUT_READY=1 and IN_VALID=1 occur together, the block SHALL retire the result and accept the new op in the same cycle, with no bubble.
REQ-026 When DONE and OUT_READY=1 with IN_VALID=0, the block SHALL go to IDLE and drop OUT_VALID the next cycle.
REQ-027 FLUSH=1 in any state SHALL force IDLE on the next edge.
  - OUT_VALID=0 and the count =0 from then on.
  - Any in-flight shift or pending result is discarded.
  - Any simultaneous offer is not accepted.
REQ-028 OUT_VALID SHALL never be high in IDLE or SHIFT.
REQ-029 RESULT SHALL change only on accept, on a SHIFT step, or at reset.

Reset
REQ-030 While NRST=0, the block SHALL set the state to IDLE and take IN_READY=1.
  - OUT_VALID=0, RESULT=0, RD_OUT=0, ERR=0, BUSY=0, count=0.
  - These values apply immediately, without waiting for CLK.
REQ-031 Deasserting NRST during SHIFT SHALL lose the operation; after reset the block SHALL accept on the first edge with IN_VALID=1.

Verification
REQ-032 The bench SHALL cover: SUB with OP_A=5, OP_B=7, OUT_READY=1 -> one cycle later OUT_VALID=1, RESULT=0xFFFFFFFE, ERR=0, RD_OUT=RD_IN.
REQ-033 The bench SHALL cover: SRA with OP_A=0x80000000, OP_B=4 -> BUSY for 5 cycles, OUT_VALID on cycle 5, RESULT=0xF8000000.
REQ-034 The bench SHALL cover: SLL with OP_B=0x20 (count 0), OP_A=0x1234 -> RESULT=0x1234 at latency 1.
REQ-035 The bench SHALL cover: SLT with OP_A=0xFFFFFFFF, OP_B=1 -> RESULT=1; SLTU with the same operands -> RESULT=0; driven back-to-back with OUT_READY=1, IN_READY stays 1 and results arrive on consecutive cycles.
REQ-036 The bench SHALL cover: FLUSH during an SRL with count 31 at step 10 -> next cycle IDLE, OUT_VALID=0, no result ever emitted; a following ADD 1+2 -> RESULT=3.
REQ-037 The bench SHALL cover: OPCODE_ALU=15 -> RESULT=0 and ERR=1; OUT_READY held 0 for 3 cycles keeps the output stable with IN_READY=0; NRST pulsed low mid-hold -> all outputs 0 immediately.
